mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single physical memory port between instruction fetch (IF) and load/store (LS) requesters.
- One outstanding transaction at a time: arbitrate, issue to memory, wait for the response, route it back to the owner.
- LS has fixed priority, with a starvation guard so fetch always progresses.
- Sits between ifu/lsu and the pmem bridge; all data and address widths follow `CPU_WIDTH` from config.sv.

Parameters:
- CPU_WIDTH, 64, address/data width (taken from `CPU_WIDTH`).
- STARVE_MAX, 4, consecutive LS grants allowed while IF is waiting before IF is forced ahead (1..15).

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_if_valid  in  1  IF read request.
- i_if_addr  in  CPU_WIDTH  IF read address.
- o_if_ready  out  1  IF request accepted this cycle.
- o_if_rvalid  out  1  one-cycle pulse, o_if_rdata valid.
- o_if_rdata  out  CPU_WIDTH  IF read data.
- i_ls_valid  in  1  LS request.
- i_ls_wen  in  1  1 = write, 0 = read.
- i_ls_addr  in  CPU_WIDTH  LS address.
- i_ls_wdata  in  CPU_WIDTH  LS write data.
- i_ls_wmask  in  8  LS byte-enable.
- o_ls_ready  out  1  LS request accepted.
- o_ls_rvalid  out  1  one-cycle pulse: read data valid, or write acknowledged.
- o_ls_rdata  out  CPU_WIDTH  LS read data (0 for writes).
- o_mem_valid  out  1  request to memory.
- o_mem_wen  out  1  write.
- o_mem_addr  out  CPU_WIDTH  memory address.
- o_mem_wdata  out  CPU_WIDTH  memory write data.
- o_mem_wmask  out  8  memory byte-enable (0 on reads).
- i_mem_ready  in  1  memory accepted request.
- i_mem_rvalid  in  1  memory response valid.
- i_mem_rdata  in  CPU_WIDTH  memory read data.

Behaviour:
- Reset values (i_rst=1 at a clock edge): state IDLE, starvation counter 0, owner latch 0.
  - All outputs are 0; all registered outputs read 0 in the cycle after reset.
  - Reset mid-transaction abandons it; no rvalid is ever produced for the abandoned transaction.
- States: IDLE, REQ, RESP.
- IDLE:
  - Grant is combinational: o_ls_ready = i_ls_valid && !force_if; o_if_ready = i_if_valid && (!i_ls_valid || force_if). At most one ready is high.
  - force_if = (cnt == STARVE_MAX) && i_if_valid.
  - On handshake (valid && ready): latch addr, wen, wdata, wmask and owner (IF or LS), then go to REQ.
  - IF requests are latched with wen=0 and wmask=0.
- REQ:
  - o_mem_valid=1; o_mem_* driven from the latch and held stable until i_mem_ready.
  - On i_mem_ready go to RESP. No ready is asserted toward requesters in REQ or RESP.
- RESP:
  - o_mem_valid=0. Wait for i_mem_rvalid.
  - On rvalid: register i_mem_rdata into the owner's rdata (LS writes: 0), pulse the owner's rvalid the next cycle, go to IDLE.
  - A new request may be accepted in the same cycle the rvalid pulse is visible.
  - i_mem_rvalid outside RESP is ignored; the memory responds no earlier than the cycle after i_mem_ready.
- Non-owner rdata holds its last value; the non-owner rvalid stays 0.
- Starvation counter, 4 bits, updated on LS handshake only:
  - Increments when i_if_valid=1, saturating at STARVE_MAX.
  - Clears on any IF handshake.
  - Clears on an LS handshake with i_if_valid=0.
- Best-case latency with zero-wait memory (i_mem_ready high in REQ, rvalid the following cycle):
  - Handshake in cycle t, o_mem_valid in t+1, rvalid seen in t+2, owner rvalid in t+3.
  - Throughput is 1 transaction per 3 cycles.
- Simultaneous valid: LS wins unless force_if.
- Requester valid is allowed to drop before ready; nothing is latched in that case.

Decomposition:
- Shared package `mem_pkg`:
  - state enum typedef (IDLE/REQ/RESP).
  - owner enum (OWN_IF/OWN_LS).
  - packed request struct {addr, wen, wdata, wmask}.
  - STARVE_MAX default constant.
- Natural sub-module: `mem_arb_grant`, the combinational grant plus starvation counter, kept separate so priority policy can be swapped. The FSM and response routing stay in mem_arbiter.

Test Plan:
- IF-only read: i_if_valid=1, addr 0x80000000, memory returns 0x00000013 one cycle after ready. Required: o_if_ready at t, o_mem_valid/addr 0x80000000 at t+1, o_if_rvalid with rdata 0x13 at t+3.
- Simultaneous IF and LS read (addr 0x80001000): LS granted first, IF served second. o_ls_rvalid precedes o_if_rvalid; o_if_ready stays 0 until the state returns to IDLE.
- Starvation with STARVE_MAX=4: LS and IF valid continuously. Grants are exactly LS,LS,LS,LS,IF,LS,…; the counter clears after the IF grant.
- LS write: addr 0x80002000, wdata 0xDEADBEEF, wmask 0x0F, i_mem_ready delayed 3 cycles. o_mem_* stay stable all 3 cycles; o_ls_rvalid pulses once with rdata 0.
- Reset in RESP: assert i_rst for one cycle, then deliver i_mem_rvalid. No rvalid pulse, all outputs 0, and a fresh IF request is accepted next cycle.
- Stray i_mem_rvalid in IDLE and REQ is ignored: no rvalid on either requester, and the state is unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory-port arbiter.
package mem_pkg;

    localparam int CPU_W          = 64;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    typedef struct packed {
        logic [CPU_W-1:0] addr;
        logic             wen;
        logic [CPU_W-1:0] wdata;
        logic [7:0]       wmask;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant policy: LS has fixed priority, IF is forced ahead after STARVE_MAX
// consecutive LS grants taken while IF was waiting.
module mem_arb_grant
    import mem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_idle,
    input  logic i_if_valid,
    input  logic i_ls_valid,
    output logic o_if_grant,
    output logic o_ls_grant
);

    logic [3:0] cnt_q, cnt_d;
    logic       force_if;

    // Combinational grant and next starvation count (moves only on handshakes).
    always_comb begin
        force_if   = (cnt_q == 4'(STARVE_MAX)) && i_if_valid;
        o_ls_grant = i_idle && i_ls_valid && !force_if;
        o_if_grant = i_idle && i_if_valid && (!i_ls_valid || force_if);
        cnt_d      = cnt_q;
        if (o_if_grant) begin
            cnt_d = 4'd0;
        end else if (o_ls_grant) begin
            if (!i_if_valid) begin
                cnt_d = 4'd0;
            end else if (cnt_q != 4'(STARVE_MAX)) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IF and LS, one transaction in flight:
// arbitrate in IDLE, present the latched request in REQ, route the reply in RESP.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int CPU_WIDTH  = CPU_W,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_if_valid,
    input  logic [CPU_WIDTH-1:0] i_if_addr,
    output logic                 o_if_ready,
    output logic                 o_if_rvalid,
    output logic [CPU_WIDTH-1:0] o_if_rdata,
    input  logic                 i_ls_valid,
    input  logic                 i_ls_wen,
    input  logic [CPU_WIDTH-1:0] i_ls_addr,
    input  logic [CPU_WIDTH-1:0] i_ls_wdata,
    input  logic [7:0]           i_ls_wmask,
    output logic                 o_ls_ready,
    output logic                 o_ls_rvalid,
    output logic [CPU_WIDTH-1:0] o_ls_rdata,
    output logic                 o_mem_valid,
    output logic                 o_mem_wen,
    output logic [CPU_WIDTH-1:0] o_mem_addr,
    output logic [CPU_WIDTH-1:0] o_mem_wdata,
    output logic [7:0]           o_mem_wmask,
    input  logic                 i_mem_ready,
    input  logic                 i_mem_rvalid,
    input  logic [CPU_WIDTH-1:0] i_mem_rdata
);

    state_e               state_q, state_d;
    owner_e               owner_q, owner_d;
    mem_req_t             req_q, req_d;
    logic                 if_rvalid_q, if_rvalid_d;
    logic                 ls_rvalid_q, ls_rvalid_d;
    logic [CPU_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [CPU_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
    logic                 arb_idle;
    logic                 if_grant, ls_grant;

    // Requesters are only offered a grant in IDLE and never while reset is held.
    assign arb_idle = (state_q == IDLE) && !i_rst;

    mem_arb_grant #(
        .STARVE_MAX (STARVE_MAX)
    ) u_grant (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_idle     (arb_idle),
        .i_if_valid (i_if_valid),
        .i_ls_valid (i_ls_valid),
        .o_if_grant (if_grant),
        .o_ls_grant (ls_grant)
    );

    // Next-state, request latch and response routing.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        req_d       = req_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ls_grant) begin
                    req_d.addr  = i_ls_addr;
                    req_d.wen   = i_ls_wen;
                    req_d.wdata = i_ls_wdata;
                    req_d.wmask = i_ls_wen ? i_ls_wmask : 8'h00;
                    owner_d     = OWN_LS;
                    state_d     = REQ;
                end else if (if_grant) begin
                    req_d.addr  = i_if_addr;
                    req_d.wen   = 1'b0;
                    req_d.wdata = '0;
                    req_d.wmask = 8'h00;
                    owner_d     = OWN_IF;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (i_mem_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (i_mem_rvalid) begin
                    state_d = IDLE;
                    if (owner_q == OWN_LS) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = req_q.wen ? '0 : i_mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = i_mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, owner and registered response outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    // Request latch is pure data; memory outputs are gated by REQ so it needs no reset.
    always_ff @(posedge i_clk) begin
        req_q <= req_d;
    end

    assign o_if_ready  = if_grant;
    assign o_ls_ready  = ls_grant;
    assign o_if_rvalid = if_rvalid_q;
    assign o_ls_rvalid = ls_rvalid_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_ls_rdata  = ls_rdata_q;
    assign o_mem_valid = (state_q == REQ);
    assign o_mem_wen   = o_mem_valid && req_q.wen;
    assign o_mem_addr  = o_mem_valid ? req_q.addr  : '0;
    assign o_mem_wdata = o_mem_valid ? req_q.wdata : '0;
    assign o_mem_wmask = o_mem_valid ? req_q.wmask : 8'h00;

endmodule
